io_led_seq: RTL and testbench

IO_LED_SEQ -- requirements
Module: io_led_seq

---
 rtl/io_led_seq_pkg.sv | 61 ++++++
 rtl/io_led_seq_timer.sv | 28 ++
 rtl/io_led_seq.sv | 142 ++++++++++++++
 tb/tb_io_led_seq.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/io_led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: register map, CTRL layout,
// FSM state type and the packed/expanded LED pattern conversions.
package io_led_seq_pkg;

    localparam int unsigned ADR_W  = 14;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned CNT_W  = 24;
    localparam int unsigned IDX_W  = 3;
    localparam int unsigned PAT_N  = 8;
    localparam int unsigned PAT_W  = 12;

    // Word offsets from the block's base address
    localparam logic [ADR_W-1:0] OFS_CTRL     = 14'd0;
    localparam logic [ADR_W-1:0] OFS_INTERVAL = 14'd1;
    localparam logic [ADR_W-1:0] OFS_STATUS   = 14'd2;
    localparam logic [ADR_W-1:0] OFS_PAT0     = 14'd4;
    localparam logic [ADR_W-1:0] OFS_PAT_LAST = 14'd11;

    localparam int unsigned CTRL_EN_BIT      = 0;
    localparam int unsigned CTRL_ONESHOT_BIT = 1;
    localparam int unsigned CTRL_LAST_LSB    = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [IDX_W-1:0] last;
        logic             oneshot;
        logic             en;
    } ctrl_t;

    function automatic ctrl_t ctrl_from_word(input logic [DATA_W-1:0] w);
        ctrl_t c;
        c.last    = w[CTRL_LAST_LSB +: IDX_W];
        c.oneshot = w[CTRL_ONESHOT_BIT];
        c.en      = w[CTRL_EN_BIT];
        return c;
    endfunction

    function automatic logic [DATA_W-1:0] ctrl_to_word(input ctrl_t c);
        return {25'd0, c.last, 2'd0, c.oneshot, c.en};
    endfunction

    function automatic logic [DATA_W-1:0] status_word(input logic busy,
                                                      input logic [IDX_W-1:0] idx);
        return {25'd0, idx, 3'd0, busy};
    endfunction

    // Four 3-bit LED fields live on nibble boundaries of the bus word
    function automatic logic [PAT_W-1:0] led_pack(input logic [DATA_W-1:0] w);
        return {w[14:12], w[10:8], w[6:4], w[2:0]};
    endfunction

    function automatic logic [DATA_W-1:0] led_unpack(input logic [PAT_W-1:0] p);
        return {17'd0, p[11:9], 1'b0, p[8:6], 1'b0, p[5:3], 1'b0, p[2:0]};
    endfunction

endpackage

// File: rtl/io_led_seq_timer.sv
// Step hold-time counter: cleared on load, counts while enabled, flags the
// cycle on which the count reaches the terminal value.
module io_led_seq_timer
    import io_led_seq_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             tc_c
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CNT_W'(1);
        end
    end

    assign tc_c = en && (count == term);

endmodule

// File: rtl/io_led_seq.sv
// LED pattern sequencer sitting on the CPU IO write path: passes CPU traffic
// through untouched and injects periodic LED register writes in idle slots.
module io_led_seq
    import io_led_seq_pkg::*;
#(
    parameter logic [ADR_W-1:0] SYS_LED_ADR  = 14'h3F80,
    parameter logic [ADR_W-1:0] SEQ_BASE_ADR = 14'h3F84
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_io_we,
    input  logic [ADR_W-1:0]  cpu_io_wadr,
    input  logic [DATA_W-1:0] cpu_io_wdata,
    input  logic [ADR_W-1:0]  cpu_io_radr,
    output logic              dma_io_we,
    output logic [ADR_W-1:0]  dma_io_wadr,
    output logic [DATA_W-1:0] dma_io_wdata,
    output logic [ADR_W-1:0]  dma_io_radr,
    input  logic [DATA_W-1:0] dma_io_rdata_in,
    output logic [DATA_W-1:0] dma_io_rdata,
    output logic              seq_busy
);

    seq_state_e       state;
    ctrl_t            ctrl;
    logic [CNT_W-1:0] interval;
    logic [PAT_W-1:0] pat [PAT_N];
    logic [IDX_W-1:0] idx;

    logic [ADR_W-1:0] wofs;
    logic [ADR_W-1:0] rofs;
    logic             wr_ctrl;
    logic             wr_interval;
    logic             wr_pat;
    logic [IDX_W-1:0] wr_pat_idx;
    logic [IDX_W-1:0] rd_pat_idx;
    logic [IDX_W-1:0] idx_next;
    logic [CNT_W-1:0] term;
    logic             seq_fire;
    logic             tc;

    // Offsets wrap modulo 2^14, so addresses below the base never alias a register
    assign wofs        = cpu_io_wadr - SEQ_BASE_ADR;
    assign rofs        = cpu_io_radr - SEQ_BASE_ADR;
    assign wr_ctrl     = cpu_io_we && (wofs == OFS_CTRL);
    assign wr_interval = cpu_io_we && (wofs == OFS_INTERVAL);
    assign wr_pat      = cpu_io_we && (wofs >= OFS_PAT0) && (wofs <= OFS_PAT_LAST);
    assign wr_pat_idx  = IDX_W'(wofs - OFS_PAT0);
    assign rd_pat_idx  = IDX_W'(rofs - OFS_PAT0);

    assign idx_next = (idx == ctrl.last) ? '0 : idx + IDX_W'(1);
    assign term     = (interval == '0) ? '0 : interval - CNT_W'(1);
    assign seq_fire = (state == ST_ISSUE) && !cpu_io_we;

    io_led_seq_timer u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (seq_fire),
        .en    (state == ST_WAIT),
        .term  (term),
        .tc_c  (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(PAT_N); i++) begin
                pat[i] <= '0;
            end
        end else if (wr_pat) begin
            pat[wr_pat_idx] <= led_pack(cpu_io_wdata);
        end
    end

    // Control registers and sequencer FSM; a CPU write clearing EN overrides everything
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            ctrl     <= '0;
            interval <= '0;
            idx      <= '0;
        end else begin
            if (wr_interval) begin
                interval <= cpu_io_wdata[CNT_W-1:0];
            end
            if (wr_ctrl) begin
                ctrl <= ctrl_from_word(cpu_io_wdata);
            end
            if (wr_ctrl && !cpu_io_wdata[CTRL_EN_BIT]) begin
                state <= ST_IDLE;
                idx   <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (wr_ctrl) begin
                            state <= ST_ISSUE;
                            idx   <= '0;
                        end
                    end
                    ST_ISSUE: begin
                        if (!cpu_io_we) begin
                            if (ctrl.oneshot && (idx == ctrl.last)) begin
                                ctrl.en <= 1'b0;
                                state   <= ST_IDLE;
                                idx     <= '0;
                            end else begin
                                state <= ST_WAIT;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (tc) begin
                            idx   <= idx_next;
                            state <= ST_ISSUE;
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    // CPU writes always win the shared write port
    assign dma_io_we    = cpu_io_we | seq_fire;
    assign dma_io_wadr  = seq_fire ? SYS_LED_ADR : cpu_io_wadr;
    assign dma_io_wdata = seq_fire ? led_unpack(pat[idx]) : cpu_io_wdata;
    assign dma_io_radr  = cpu_io_radr;
    assign seq_busy     = (state != ST_IDLE);

    always_comb begin
        dma_io_rdata = dma_io_rdata_in;
        if (rofs == OFS_CTRL) begin
            dma_io_rdata = ctrl_to_word(ctrl);
        end else if (rofs == OFS_INTERVAL) begin
            dma_io_rdata = DATA_W'(interval);
        end else if (rofs == OFS_STATUS) begin
            dma_io_rdata = status_word(seq_busy, idx);
        end else if ((rofs >= OFS_PAT0) && (rofs <= OFS_PAT_LAST)) begin
            dma_io_rdata = led_unpack(pat[rd_pat_idx]);
        end
    end

endmodule

// File: tb/tb_io_led_seq.sv
// Bench for io_led_seq: behavioural reference checked every cycle, directed
// scenarios with literal expectations, then a randomized CPU traffic run.
module tb_io_led_seq;

    localparam logic [13:0] LED  = 14'h3F80;
    localparam logic [13:0] BASE = 14'h3F84;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cpu_io_we = 1'b0;
    logic [13:0] cpu_io_wadr = '0;
    logic [31:0] cpu_io_wdata = '0;
    logic [13:0] cpu_io_radr = '0;
    logic        dma_io_we;
    logic [13:0] dma_io_wadr;
    logic [31:0] dma_io_wdata;
    logic [13:0] dma_io_radr;
    logic [31:0] dma_io_rdata_in = '0;
    logic [31:0] dma_io_rdata;
    logic        seq_busy;

    io_led_seq #(.SYS_LED_ADR(LED), .SEQ_BASE_ADR(BASE)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .cpu_io_we       (cpu_io_we),
        .cpu_io_wadr     (cpu_io_wadr),
        .cpu_io_wdata    (cpu_io_wdata),
        .cpu_io_radr     (cpu_io_radr),
        .dma_io_we       (dma_io_we),
        .dma_io_wadr     (dma_io_wadr),
        .dma_io_wdata    (dma_io_wdata),
        .dma_io_radr     (dma_io_radr),
        .dma_io_rdata_in (dma_io_rdata_in),
        .dma_io_rdata    (dma_io_rdata),
        .seq_busy        (seq_busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int log_cyc[$];
    logic [31:0] log_dat[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference: a run is "active" with an issue either pending or a hold in progress
    bit          m_en, m_one, m_active, m_pending;
    int          m_last, m_iv, m_idx, m_elapsed;
    logic [31:0] m_pat [8];

    function automatic logic [31:0] model_rd(input logic [13:0] a, input logic [31:0] rin);
        int off;
        off = int'(a) - int'(BASE);
        if (off == 0) return 32'((m_last << 4) | (int'(m_one) << 1) | int'(m_en));
        if (off == 1) return 32'(m_iv);
        if (off == 2) return 32'((m_idx << 4) | int'(m_active));
        if (off >= 4 && off <= 11) return m_pat[off-4];
        return rin;
    endfunction

    task automatic model_reset();
        m_en = 0; m_one = 0; m_active = 0; m_pending = 0;
        m_last = 0; m_iv = 0; m_idx = 0; m_elapsed = 0;
        for (int i = 0; i < 8; i++) m_pat[i] = '0;
    endtask

    task automatic model_step();
        int off, old_last;
        bit we, old_one;
        logic [31:0] wd;
        we = (cpu_io_we === 1'b1);
        wd = cpu_io_wdata;
        off = int'(cpu_io_wadr) - int'(BASE);
        old_last = m_last;
        old_one = m_one;
        if (we && off == 1) m_iv = int'(wd[23:0]);
        if (we && off >= 4 && off <= 11) m_pat[off-4] = wd & 32'h0000_7777;
        if (we && off == 0) begin
            m_en = wd[0]; m_one = wd[1]; m_last = int'(wd[6:4]);
        end
        if (we && off == 0 && !wd[0]) begin
            m_active = 0; m_pending = 0; m_idx = 0;
        end else if (!m_active) begin
            if (we && off == 0) begin
                m_active = 1; m_pending = 1; m_idx = 0;
            end
        end else if (m_pending) begin
            if (!we) begin
                if (old_one && m_idx == old_last) begin
                    m_en = 0; m_active = 0; m_pending = 0; m_idx = 0;
                end else begin
                    m_pending = 0; m_elapsed = 0;
                end
            end
        end else begin
            m_elapsed++;
            if (m_elapsed >= ((m_iv == 0) ? 1 : m_iv)) begin
                m_pending = 1;
                m_idx = (m_idx == old_last) ? 0 : (m_idx + 1) % 8;
            end
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else model_step();
    end

    // Per-cycle comparison of every output against the reference
    always @(negedge clk) begin
        logic        e_we;
        logic [13:0] e_adr;
        logic [31:0] e_dat;
        e_we = 1'b0; e_adr = '0; e_dat = '0;
        if (cpu_io_we === 1'b1) begin
            e_we = 1'b1; e_adr = cpu_io_wadr; e_dat = cpu_io_wdata;
        end else if (m_active && m_pending) begin
            e_we = 1'b1; e_adr = LED; e_dat = m_pat[m_idx];
        end
        chk("we", 32'(dma_io_we), 32'(e_we));
        if (e_we) begin
            chk("wadr", 32'(dma_io_wadr), 32'(e_adr));
            chk("wdata", dma_io_wdata, e_dat);
        end
        chk("radr", 32'(dma_io_radr), 32'(cpu_io_radr));
        chk("rdata", dma_io_rdata, model_rd(cpu_io_radr, dma_io_rdata_in));
        chk("busy", 32'(seq_busy), 32'(m_active));
        if (dma_io_we === 1'b1 && cpu_io_we === 1'b0 && dma_io_wadr === LED) begin
            log_cyc.push_back(cyc);
            log_dat.push_back(dma_io_wdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        cpu_io_we = 1'b0;
        dma_io_rdata_in = $urandom;
    endtask

    task automatic wr(input logic [13:0] a, input logic [31:0] d);
        cpu_io_we = 1'b1; cpu_io_wadr = a; cpu_io_wdata = d;
        tick();
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic read_chk(input string nm, input logic [13:0] a, input logic [31:0] rin,
                            input logic [31:0] exp);
        cpu_io_radr = a;
        dma_io_rdata_in = rin;
        #1;
        chk(nm, dma_io_rdata, exp);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    function automatic logic [13:0] pick_adr();
        int r;
        r = int'($urandom_range(0, 15));
        if (r < 12) return BASE + 14'(r);
        if (r == 12) return LED;
        if (r == 13) return BASE + 14'd12;
        return 14'($urandom);
    endfunction

    initial begin
        int c0;
        logic [31:0] d;
        logic [13:0] a;

        // Reset state
        cpu_io_radr = BASE;
        tick();
        tick();
        chk("rst_busy", 32'(seq_busy), 32'd0);
        chk("rst_we", 32'(dma_io_we), 32'd0);
        read_chk("rst_ctrl", BASE, 32'h5555_5555, 32'd0);
        rst_n = 1'b1;
        tick();

        // Two-step alternating pattern, hold 4
        wr(BASE + 14'd4, 32'h7);
        wr(BASE + 14'd5, 32'h70);
        wr(BASE + 14'd1, 32'd4);
        log_cyc.delete(); log_dat.delete();
        c0 = cyc;
        wr(BASE, 32'h11);
        idle(20);
        chk("alt_nwrites", 32'(log_dat.size()), 32'd4);
        if (log_dat.size() >= 3) begin
            chk("alt_first_cyc", 32'(log_cyc[0]), 32'(c0 + 1));
            chk("alt_d0", log_dat[0], 32'h7);
            chk("alt_d1", log_dat[1], 32'h70);
            chk("alt_d2", log_dat[2], 32'h7);
            chk("alt_gap01", 32'(log_cyc[1] - log_cyc[0]), 32'd5);
            chk("alt_gap12", 32'(log_cyc[2] - log_cyc[1]), 32'd5);
        end

        // CPU write collides with the issue slot
        do_reset();
        wr(BASE + 14'd4, 32'h7);
        wr(BASE + 14'd5, 32'h70);
        wr(BASE + 14'd1, 32'd4);
        log_cyc.delete(); log_dat.delete();
        c0 = cyc;
        wr(BASE, 32'h11);
        idle(5);
        cpu_io_we = 1'b1; cpu_io_wadr = LED; cpu_io_wdata = 32'hABC;
        #1;
        chk("col_cpu_adr", 32'(dma_io_wadr), 32'(LED));
        chk("col_cpu_data", dma_io_wdata, 32'hABC);
        tick();
        idle(2);
        chk("col_nwrites", 32'(log_dat.size()), 32'd2);
        if (log_dat.size() >= 2) begin
            chk("col_retry_cyc", 32'(log_cyc[1]), 32'(c0 + 7));
            chk("col_retry_data", log_dat[1], 32'h70);
        end

        // One-shot over three steps
        do_reset();
        wr(BASE + 14'd4, 32'h1);
        wr(BASE + 14'd5, 32'h2);
        wr(BASE + 14'd6, 32'h3);
        wr(BASE + 14'd1, 32'd1);
        log_cyc.delete(); log_dat.delete();
        wr(BASE, 32'h23);
        idle(15);
        chk("os_nwrites", 32'(log_dat.size()), 32'd3);
        if (log_dat.size() == 3) chk("os_span", 32'(log_cyc[2] - log_cyc[0]), 32'd4);
        read_chk("os_ctrl", BASE, 32'h0, 32'h22);
        chk("os_busy", 32'(seq_busy), 32'd0);

        // EN cleared mid-hold
        do_reset();
        wr(BASE + 14'd1, 32'd100);
        wr(BASE + 14'd4, 32'h5);
        log_cyc.delete(); log_dat.delete();
        wr(BASE, 32'h1);
        idle(10);
        wr(BASE, 32'h0);
        idle(120);
        chk("stop_nwrites", 32'(log_dat.size()), 32'd1);
        read_chk("stop_status", BASE + 14'd2, 32'hFFFF_FFFF, 32'd0);
        chk("stop_busy", 32'(seq_busy), 32'd0);

        // Reset pulse mid-hold clears everything
        do_reset();
        for (int k = 0; k < 8; k++) wr(BASE + 14'(4 + k), 32'h1111 | $urandom);
        wr(BASE + 14'd1, 32'd20);
        log_cyc.delete(); log_dat.delete();
        wr(BASE, 32'h71);
        idle(6);
        do_reset();
        for (int k = 0; k < 12; k++) begin
            if (k != 3) read_chk("rst_reg", BASE + 14'(k), 32'hDEAD_BEEF, 32'd0);
        end
        idle(40);
        chk("rst_nwrites", 32'(log_dat.size()), 32'd1);

        // Zero interval behaves as one; unmapped reads pass through
        do_reset();
        wr(BASE + 14'd4, 32'h1);
        wr(BASE + 14'd5, 32'h10);
        wr(BASE + 14'd6, 32'h100);
        wr(BASE + 14'd7, 32'h1000);
        wr(BASE + 14'd1, 32'd0);
        log_cyc.delete(); log_dat.delete();
        wr(BASE, 32'h31);
        idle(10);
        chk("z_nwrites", 32'(log_dat.size()), 32'd5);
        if (log_dat.size() == 5) begin
            for (int k = 0; k < 4; k++) chk("z_gap", 32'(log_cyc[k+1] - log_cyc[k]), 32'd2);
            chk("z_d3", log_dat[3], 32'h1000);
            chk("z_d4", log_dat[4], 32'h1);
        end
        read_chk("unmap_b3", BASE + 14'd3, 32'h1357_9BDF, 32'h1357_9BDF);
        read_chk("unmap_b12", BASE + 14'd12, 32'h2468_ACE0, 32'h2468_ACE0);
        read_chk("unmap_low", 14'h0010, 32'hCAFE_F00D, 32'hCAFE_F00D);

        // Randomized CPU traffic against the reference
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            cpu_io_radr = pick_adr();
            if ($urandom_range(0, 3) == 0) begin
                a = pick_adr();
                d = $urandom;
                if (a == BASE + 14'd1) begin
                    if (m_active) a = LED;
                    else d = 32'($urandom_range(0, 5));
                end
                if (a == BASE) begin
                    d[0] = ($urandom_range(0, 4) != 0);
                    d[1] = ($urandom_range(0, 3) == 0);
                end
                wr(a, d);
            end else begin
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
